serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 145 ++++++++++++++
 tb/tb_serial_subtractor.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b one bit per clock through a single full adder (a + ~b + 1).
// Optional signed-overflow output enabled by defining SUB_OVF_EN.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic             carry_r;
    logic [CW-1:0]    cnt_r;
    logic             sum_s;
    logic             cout_s;
    logic             last_s;
`ifdef SUB_OVF_EN
    logic             a_msb_r;
    logic             b_msb_r;
`endif

    // Full-adder slice on the current LSBs, with the subtrahend inverted.
    always_comb begin
        sum_s  = a_sh_r[0] ^ ~b_sh_r[0] ^ carry_r;
        cout_s = (a_sh_r[0] & ~b_sh_r[0]) | (carry_r & (a_sh_r[0] ^ ~b_sh_r[0]));
        last_s = (cnt_r == CW'(WIDTH - 1));
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = SHIFT;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Status flags registered from the next state so they line up with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_s != IDLE);
            done <= (state_s == DONE);
        end
    end

    // Serial datapath: operand capture, shifting, and result/borrow accumulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh_r  <= '0;
            b_sh_r  <= '0;
            carry_r <= 1'b0;
            cnt_r   <= '0;
            diff    <= '0;
            borrow  <= 1'b0;
`ifdef SUB_OVF_EN
            a_msb_r <= 1'b0;
            b_msb_r <= 1'b0;
            ovf     <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        a_sh_r  <= a;
                        b_sh_r  <= b;
                        carry_r <= 1'b1;
                        cnt_r   <= '0;
`ifdef SUB_OVF_EN
                        a_msb_r <= a[WIDTH-1];
                        b_msb_r <= b[WIDTH-1];
`endif
                    end
                end
                SHIFT: begin
                    a_sh_r  <= {1'b0, a_sh_r[WIDTH-1:1]};
                    b_sh_r  <= {1'b0, b_sh_r[WIDTH-1:1]};
                    carry_r <= cout_s;
                    cnt_r   <= cnt_r + CW'(1);
                    diff    <= {sum_s, diff[WIDTH-1:1]};
                    if (last_s) begin
                        // No final carry out means the minuend was smaller.
                        borrow <= ~cout_s;
`ifdef SUB_OVF_EN
                        ovf    <= (a_msb_r != b_msb_r) && (sum_s != a_msb_r);
`endif
                    end
                end
                DONE: begin
                    carry_r <= carry_r;
                end
                default: begin
                    carry_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed and random operations against an arithmetic reference.
module tb_serial_subtractor;

    localparam int WIDTH = 4;
    localparam int MASK  = (1 << WIDTH) - 1;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
`ifdef SUB_OVF_EN
    logic             ovf;
`endif

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
`ifdef SUB_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int to_signed(input int v);
        return (v >= (1 << (WIDTH - 1))) ? v - (1 << WIDTH) : v;
    endfunction

    // Launches one operation (caller is between clock edges, in IDLE) and checks its result.
    task automatic do_op(input int av, input int bv, input bit disturb);
        int exp_diff;
        int exp_borrow;
        int exp_ovf;
        int sd;
        int lat;
        int bcnt;
        int extra;
        exp_diff   = (av - bv) & MASK;
        exp_borrow = (av < bv) ? 1 : 0;
        sd         = to_signed(av) - to_signed(bv);
        exp_ovf    = (sd > (1 << (WIDTH - 1)) - 1 || sd < -(1 << (WIDTH - 1))) ? 1 : 0;
        a     = WIDTH'(av);
        b     = WIDTH'(bv);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (disturb) begin
            a = '0;
            b = '0;
        end
        lat  = 0;
        bcnt = busy ? 1 : 0;
        for (int i = 1; i <= WIDTH + 4; i++) begin
            if (disturb && i == 2) start = 1'b1;
            if (disturb && i == 3) start = 1'b0;
            @(posedge clk);
            #1;
            if (busy) bcnt++;
            if (done) begin
                lat = i;
                break;
            end
        end
        check("latency", lat, WIDTH);
        check("busy_cycles", bcnt, WIDTH + 1);
        check("diff", 32'(diff), exp_diff);
        check("borrow", 32'(borrow), exp_borrow);
`ifdef SUB_OVF_EN
        check("ovf", 32'(ovf), exp_ovf);
`endif
        @(posedge clk);
        #1;
        check("done_pulse_width", 32'(done), 0);
        check("idle_busy", 32'(busy), 0);
        check("diff_held", 32'(diff), exp_diff);
        if (disturb) begin
            extra = 0;
            for (int i = 0; i < 10; i++) begin
                @(posedge clk);
                #1;
                if (done) extra++;
            end
            check("no_extra_done", extra, 0);
        end
        @(negedge clk);
    endtask

    initial begin
        int ra;
        int rb;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_diff", 32'(diff), 0);
        check("rst_borrow", 32'(borrow), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        do_op(9, 3, 1'b0);
        do_op(3, 9, 1'b0);
        do_op(0, 1, 1'b0);
        do_op(5, 5, 1'b0);
        do_op(11, 0, 1'b0);
        do_op(0, 0, 1'b0);
        do_op(15, 15, 1'b0);
        do_op(7, 8, 1'b0);
        do_op(2, 1, 1'b0);
        do_op(8, 1, 1'b0);

        // Idle hold: nothing changes without start.
        repeat (3) @(posedge clk);
        #1;
        check("idle_hold_diff", 32'(diff), 32'((8 - 1) & MASK));
        check("idle_hold_busy", 32'(busy), 0);
        @(negedge clk);

        // start held high: one op every WIDTH+2 cycles.
        a     = WIDTH'(9);
        b     = WIDTH'(3);
        start = 1'b1;
        for (int i = 1; i <= 3 * (WIDTH + 2); i++) begin
            @(posedge clk);
            #1;
            check("held_done", 32'(done),
                  (i >= WIDTH + 1 && ((i - (WIDTH + 1)) % (WIDTH + 2)) == 0) ? 1 : 0);
            if (done) check("held_diff", 32'(diff), 6);
        end
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Operand changes and start re-pulse while busy are ignored.
        do_op(9, 3, 1'b1);

        // Asynchronous reset during SHIFT aborts the operation.
        a     = WIDTH'(9);
        b     = WIDTH'(3);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 0);
        check("arst_done", 32'(done), 0);
        check("arst_diff", 32'(diff), 0);
        check("arst_borrow", 32'(borrow), 0);
`ifdef SUB_OVF_EN
        check("arst_ovf", 32'(ovf), 0);
`endif
        @(posedge clk);
        #1;
        check("arst_no_done", 32'(done), 0);
        @(negedge clk);
        rst = 1'b0;
        do_op(12, 4, 1'b0);

        for (int k = 0; k < 25; k++) begin
            ra = int'($urandom_range(0, MASK));
            rb = int'($urandom_range(0, MASK));
            do_op(ra, rb, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
